// File: rtl/iter_div_unit_if.sv
// Request/response bundle for the iterative divider: operands and tag in,
// quotient/remainder/divide-by-zero flag and tag out, valid/ready on both sides.
interface iter_div_unit_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic             in_signed;
   logic [WIDTH-1:0] in_dividend;
   logic [WIDTH-1:0] in_divisor;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_quot;
   logic [WIDTH-1:0] out_rem;
   logic             out_dz;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_signed, in_dividend, in_divisor, in_tag, out_ready,
      input  in_ready, out_valid, out_quot, out_rem, out_dz, out_tag
   );

   modport slave (
      input  in_valid, in_signed, in_dividend, in_divisor, in_tag, out_ready,
      output in_ready, out_valid, out_quot, out_rem, out_dz, out_tag
   );
endinterface

// File: rtl/iter_div_unit.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned per operation,
// one quotient bit per cycle on magnitudes with a sign fixup at the end.
module iter_div_unit #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            flush,
   output logic            busy,
   iter_div_unit_if.slave  div
);
   localparam int CNT_W = $clog2(WIDTH);

   generate
      if (WIDTH < 4) begin : g_bad_width
         $error("iter_div_unit: WIDTH must be at least 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic             quot_neg_q;
   logic             rem_neg_q;
   logic [TAG_W-1:0] tag_q;

   logic signed [WIDTH-1:0] dividend_s;
   logic signed [WIDTH-1:0] divisor_s;
   logic                    dvd_neg;
   logic                    dvs_neg;
   logic                    accept;
   logic                    dz_in;
   logic                    last;
   logic [WIDTH:0]          trial;
   logic [WIDTH:0]          diff;
   logic                    qbit;
   logic [WIDTH-1:0]        rem_nxt;
   logic [WIDTH-1:0]        quot_nxt;

   function automatic logic [WIDTH-1:0] cond_neg(input logic neg,
                                                 input logic [WIDTH-1:0] v);
      return neg ? -v : v;
   endfunction

   assign dividend_s = div.in_dividend;
   assign divisor_s  = div.in_divisor;
   assign dvd_neg    = div.in_signed && (dividend_s < 0);
   assign dvs_neg    = div.in_signed && (divisor_s < 0);

   assign div.in_ready = (state_q == IDLE) && !flush;
   assign busy         = (state_q != IDLE);
   assign accept       = div.in_valid && div.in_ready;
   assign dz_in        = (div.in_divisor == '0);
   assign last         = (cnt_q == '0);

   // Trial subtraction: the borrow out of bit WIDTH says the divisor did not fit
   assign trial    = {rem_q, dvd_q[WIDTH-1]};
   assign diff     = trial - {1'b0, dvs_q};
   assign qbit     = ~diff[WIDTH];
   assign rem_nxt  = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quot_nxt = {dvd_q[WIDTH-2:0], qbit};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = dz_in ? DONE : CALC;
         CALC:    if (last) state_d = DONE;
         DONE:    if (div.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   // Control and result registers; a DONE result is dropped by flush even if taken
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q         <= '0;
         div.out_valid <= 1'b0;
         div.out_quot  <= '0;
         div.out_rem   <= '0;
         div.out_dz    <= 1'b0;
         div.out_tag   <= '0;
      end else if (flush) begin
         div.out_valid <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept && dz_in) begin
                  div.out_valid <= 1'b1;
                  div.out_quot  <= '1;
                  div.out_rem   <= div.in_dividend;
                  div.out_dz    <= 1'b1;
                  div.out_tag   <= div.in_tag;
               end else if (accept) begin
                  cnt_q <= CNT_W'(WIDTH - 1);
               end
            end
            CALC: begin
               if (last) begin
                  div.out_valid <= 1'b1;
                  div.out_quot  <= cond_neg(quot_neg_q, quot_nxt);
                  div.out_rem   <= cond_neg(rem_neg_q, rem_nxt);
                  div.out_dz    <= 1'b0;
                  div.out_tag   <= tag_q;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE: if (div.out_ready) div.out_valid <= 1'b0;
            default: div.out_valid <= 1'b0;
         endcase
      end
   end

   // Working registers: dvd_q shifts out dividend bits and shifts in quotient bits
   always_ff @(posedge clk) begin
      if (accept) begin
         tag_q      <= div.in_tag;
         quot_neg_q <= dvd_neg ^ dvs_neg;
         rem_neg_q  <= dvd_neg;
         dvd_q      <= cond_neg(dvd_neg, div.in_dividend);
         dvs_q      <= cond_neg(dvs_neg, div.in_divisor);
         rem_q      <= '0;
      end else if (state_q == CALC) begin
         rem_q <= rem_nxt;
         dvd_q <= quot_nxt;
      end
   end
endmodule

// File: doc/iter_div_unit.md
Name: iter_div_unit

Overview:
- Parametrised, multi-cycle radix-2 restoring divider for the EX stage.
- Generalises the current signed-only, IP-based division path: configurable width, signed/unsigned mode per operation, and quotient and remainder returned together.
- Provides a transaction tag for pipeline bookkeeping, pipeline flush/cancel, and a fast path for divide-by-zero.
- Decoupled valid/ready on both sides, so the ALU stalls on `in_ready`/`out_valid` instead of a combinational wait.

Parameters:
WIDTH   32   operand/result width in bits (>=4)
TAG_W   5    width of pass-through transaction tag

Ports:
clk          in   1        clock, all state on rising edge
resetn       in   1        asynchronous active-low reset
in_valid     in   1        operation request
in_ready     out  1        unit can accept a request
in_signed    in   1        1 = two's-complement operands, 0 = unsigned
in_dividend  in   WIDTH    dividend (rj)
in_divisor   in   WIDTH    divisor (rk)
in_tag       in   TAG_W    tag, returned unchanged with result
flush        in   1        cancel in-flight/held operation
out_valid    out  1        result available
out_ready    in   1        consumer takes result
out_quot     out  WIDTH    quotient
out_rem      out  WIDTH    remainder
out_dz       out  1        divisor was zero
out_tag      out  TAG_W    tag of this result
busy         out  1        state != IDLE

Behaviour:
- Clock and reset: one clock `clk`. Reset is asynchronous and active-low on `resetn`.
  - While `resetn`=0: state=IDLE, out_valid=0, out_quot=0, out_rem=0, out_dz=0, out_tag=0, busy=0, iteration counter=0.
  - Reset asserted mid-operation aborts it; no result is ever emitted for it.
- States: IDLE, CALC, DONE.
- in_ready = (state==IDLE) && !flush. There is no accept-while-DONE bypass.
- IDLE, on accept (in_valid && in_ready):
  - latch tag, signed flag, sign of dividend and divisor (signed mode only);
  - latch |dividend| and |divisor| as WIDTH-bit unsigned values (|MIN| = 2^(WIDTH-1), no overflow);
  - if divisor==0, go to DONE;
  - else clear partial remainder, set counter=WIDTH-1, go to CALC.
- CALC, one quotient bit per cycle, MSB first:
  - trial = {rem[WIDTH-1:0], next dividend bit}, WIDTH+1 bits;
  - if trial >= divisor: rem = trial - divisor, qbit = 1; else rem = trial, qbit = 0;
  - when counter==0, go to DONE and register sign-corrected results; else decrement counter.
- Sign fixup (signed mode):
  - quotient negated if dividend sign XOR divisor sign;
  - remainder negated if dividend sign;
  - i.e. truncating division, remainder takes the sign of the dividend.
- Special results:
  - Divisor zero: out_quot = all ones, out_rem = original dividend (unmodified, both modes), out_dz=1.
  - Signed MIN / -1: out_quot = MIN, out_rem = 0, out_dz=0. This falls out naturally from the algorithm; no special case is needed.
- Latency from the accept edge to out_valid=1:
  - normal: WIDTH+1 cycles;
  - divide-by-zero: 1 cycle.
- DONE:
  - out_valid=1; out_* held stable until out_valid && out_ready;
  - on that handshake, go to IDLE and clear out_valid. A new request is accepted one cycle later at the earliest.
- flush (highest priority after reset):
  - in any state, next state is IDLE and out_valid=0;
  - a DONE result not yet taken is discarded, even if out_ready=1 in the same cycle;
  - flush together with in_valid: in_ready is 0, so the request is not accepted.
- Outputs are registered. out_quot, out_rem and out_tag are only meaningful while out_valid=1.
- Unsupported WIDTH (<4) is a synthesis error.

Test Plan:
Bench uses WIDTH=32.
1. Signed -7 / 2 (0xFFFFFFF9 / 0x00000002, in_signed=1, tag=3) -> exactly 33 cycles after accept: out_valid=1, quot=0xFFFFFFFD, rem=0xFFFFFFFF, dz=0, tag=3.
2. Unsigned 0xFFFFFFF9 / 2 -> quot=0x7FFFFFFC, rem=0x00000001. Then signed 0x80000000 / 0xFFFFFFFF -> quot=0x80000000, rem=0.
3. Divide-by-zero 5 / 0, signed and unsigned -> out_valid 1 cycle after accept, quot=0xFFFFFFFF, rem=0x00000005, dz=1, busy deasserts after handshake.
4. Back-pressure: out_ready=0 for 10 cycles after out_valid -> outputs and tag stable, in_ready=0 throughout. Release out_ready -> in_ready=1 the next cycle; back-to-back 100/7 then 100/-7 (signed) -> quot 14 rem 2, then quot 0xFFFFFFF2 rem 2.
5. Flush at CALC cycle 10, and flush in DONE with out_ready=1 -> no result emitted in either case, IDLE/in_ready=1 next cycle. Flush with in_valid=1 -> request not accepted.
6. Assert resetn=0 asynchronously (mid-cycle) during CALC -> out_valid, busy and outputs go to 0 immediately. After release, 1000 / 10 unsigned -> quot 100, rem 0.
